// File: rtl/soc_pkg.sv
// Shared SoC definitions for the boot-time program loader.
package soc_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned LOADER_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream; lane tracking lives here only.
module byte_packer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  output logic [XLEN-1:0] word,
  output logic            word_valid,
  output logic            word_done_c
);

  localparam int unsigned BPW    = XLEN / 8;
  localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0] lane;
  logic [XLEN-1:0]   partial;
  logic [XLEN-1:0]   merged;

  // Current partial word with the incoming byte dropped into its lane
  always_comb begin
    merged = partial;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (lane == LANE_W'(i)) merged[i*8 +: 8] = in_byte;
    end
  end

  // This byte completes a word (lets the owner count words without lane state)
  always_comb begin
    word_done_c = in_valid && !clear && (lane == LAST_LANE);
  end

  // Lane counter, partial word and one-cycle word strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
      end else if (in_valid) begin
        partial <= merged;
        if (lane == LAST_LANE) begin
          lane       <= '0;
          word       <= merged;
          word_valid <= 1'b1;
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: header word count, packed data words, optional XOR checksum, then core release.
module prog_loader
  import soc_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CHECK_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned HDR_CNT_W = $clog2(LOADER_HDR_BYTES);
  localparam int unsigned WL_W      = ADDR_W + 1;

  loader_state_t        state, state_n;
  logic [HDR_CNT_W-1:0] hdr_cnt, hdr_cnt_n;
  logic [31:0]          n_q, n_n, n_full;
  logic [7:0]           acc, acc_n;
  logic [WL_W-1:0]      wl_n;
  logic [ADDR_W-1:0]    addr_n;
  logic                 rx_ready_n, busy_n, done_n, err_n, core_run_n;
  logic                 xfer;
  logic                 pack_valid;
  logic                 pack_clear;
  logic                 word_done_c;
  logic                 hdr_last;
  loader_state_t        after_data;

  assign xfer       = rx_valid && rx_ready;
  assign pack_valid = xfer && (state == DATA);
  assign pack_clear = (state != DATA);
  assign hdr_last   = (hdr_cnt == HDR_CNT_W'(LOADER_HDR_BYTES - 1));
  assign after_data = (CHECK_EN != 0) ? CSUM : DONE;

  byte_packer #(.XLEN(XLEN)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (pack_clear),
    .in_valid    (pack_valid),
    .in_byte     (rx_data),
    .word        (mem_wdata),
    .word_valid  (mem_we),
    .word_done_c (word_done_c)
  );

  // Header count with the incoming byte placed at its little-endian position
  always_comb begin
    n_full = n_q;
    for (int unsigned i = 0; i < LOADER_HDR_BYTES; i++) begin
      if (hdr_cnt == HDR_CNT_W'(i)) n_full[i*8 +: 8] = rx_data;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    hdr_cnt_n  = hdr_cnt;
    n_n        = n_q;
    acc_n      = acc;
    wl_n       = words_loaded;
    addr_n     = mem_addr;

    unique case (state)
      HDR: begin
        if (xfer) begin
          n_n       = n_full;
          hdr_cnt_n = hdr_cnt + HDR_CNT_W'(1);
          if (hdr_last) begin
            if (n_full > 32'(DEPTH))  state_n = ERR;
            else if (n_full == 32'd0) state_n = after_data;
            else                      state_n = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          acc_n = acc ^ rx_data;
          if (word_done_c) begin
            addr_n = ADDR_W'(words_loaded);
            wl_n   = words_loaded + WL_W'(1);
            // Leave DATA together with the last write so a trailing byte is never taken as data
            if ((32'(words_loaded) + 32'd1) == n_q) state_n = after_data;
          end
        end
      end
      CSUM: begin
        if (xfer) state_n = (rx_data == acc) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (restart) begin
          state_n   = HDR;
          hdr_cnt_n = '0;
          acc_n     = '0;
          wl_n      = '0;
        end
      end
      default: state_n = HDR;
    endcase

    rx_ready_n = (state_n == HDR) || (state_n == DATA) || (state_n == CSUM);
    busy_n     = rx_ready_n;
    done_n     = (state_n == DONE);
    err_n      = (state_n == ERR);
    // Release the core one cycle after DONE is entered, and drop it with restart
    core_run_n = (state == DONE) && (state_n == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR;
      hdr_cnt      <= '0;
      n_q          <= '0;
      acc          <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
      rx_ready     <= 1'b1;
      busy         <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      core_run     <= 1'b0;
    end else begin
      state        <= state_n;
      hdr_cnt      <= hdr_cnt_n;
      n_q          <= n_n;
      acc          <= acc_n;
      words_loaded <= wl_n;
      mem_addr     <= addr_n;
      rx_ready     <= rx_ready_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      core_run     <= core_run_n;
    end
  end

endmodule
